// File: rtl/proc_elem_if.sv
// Window/kernel input bundle and scaled pixel output of one convolution processing element.
// The line buffer drives it through the master modport; proc_elem sits on the slave side.
interface proc_elem_if #(
    parameter int KERNEL_SIZE    = 3,
    parameter int INPUT_CHANNELS = 1,
    parameter int PX_SIZE        = 8
) ();
    logic                                                               valid_in;
    logic [INPUT_CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] img_in;
    logic [INPUT_CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PX_SIZE-1:0] kernel;
    logic [PX_SIZE-1:0]                                                 img_out;
    logic                                                               valid_out;

    modport master (
        output valid_in,
        output img_in,
        output kernel,
        input  img_out,
        input  valid_out
    );

    modport slave (
        input  valid_in,
        input  img_in,
        input  kernel,
        output img_out,
        output valid_out
    );
endinterface

// File: rtl/proc_elem.sv
// Convolution processing element: KxKxC multiply, sum, right shift, saturate to one pixel.
// Two register stages (products, then scaled result); the pipeline never stalls.
module proc_elem #(
    parameter int KERNEL_SIZE    = 3,
    parameter int INPUT_CHANNELS = 1,
    parameter int PX_SIZE        = 8,
    parameter int SHIFT          = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    proc_elem_if.slave   pe_if
);
    localparam int NUM_IN = KERNEL_SIZE * KERNEL_SIZE * INPUT_CHANNELS;
    localparam int PROD_W = 2 * PX_SIZE;
    localparam int ACC_W  = PROD_W + $clog2(NUM_IN);

    logic [NUM_IN-1:0][PROD_W-1:0] prod_d;
    logic [NUM_IN-1:0][PROD_W-1:0] prod_q;
    logic                          valid_s1_q;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   shifted;
    logic [PX_SIZE-1:0] img_out_d;
    logic [PX_SIZE-1:0] img_out_q;
    logic               valid_out_q;

    // Flatten channel/row/column into one product vector; the sum is order-independent.
    always_comb begin
        prod_d = '0;
        for (int c = 0; c < INPUT_CHANNELS; c++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    prod_d[(c * KERNEL_SIZE + r) * KERNEL_SIZE + k] =
                        PROD_W'(pe_if.img_in[c][r][k]) * PROD_W'(pe_if.kernel[c][r][k]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            valid_s1_q <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            valid_s1_q <= pe_if.valid_in;
        end
    end

    // ACC_W is sized so the full sum of products can never wrap.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            acc = acc + ACC_W'(prod_q[i]);
        end
        shifted = acc >> SHIFT;
        if (shifted > ACC_W'({PX_SIZE{1'b1}})) begin
            img_out_d = '1;
        end else begin
            img_out_d = shifted[PX_SIZE-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            img_out_q   <= img_out_d;
            valid_out_q <= valid_s1_q;
        end
    end

    assign pe_if.img_out   = img_out_q;
    assign pe_if.valid_out = valid_out_q;
endmodule

// File: tb/tb_proc_elem.sv
// Self-checking bench for proc_elem: directed windows plus random windows checked
// against an arithmetic reference (sum of products, floor shift, clamp to 255).
module tb_proc_elem;
    localparam int KS = 3;
    localparam int CH = 1;
    localparam int PX = 8;
    localparam int SH = 3;
    localparam int N  = KS * KS * CH;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int   im_g [N];
    int   kr_g [N];
    logic v_g;

    // expected contents one and two edges after the inputs were sampled
    int   e1_px, eo_px;
    logic e1_v,  eo_v;

    proc_elem_if #(.KERNEL_SIZE(KS), .INPUT_CHANNELS(CH), .PX_SIZE(PX)) pe_if ();

    proc_elem #(
        .KERNEL_SIZE(KS), .INPUT_CHANNELS(CH), .PX_SIZE(PX), .SHIFT(SH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pe_if (pe_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_px();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += im_g[i] * kr_g[i];
        s = s / (2 ** SH);
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic drive();
        for (int r = 0; r < KS; r++) begin
            for (int k = 0; k < KS; k++) begin
                pe_if.img_in[0][r][k] = 8'(im_g[r * KS + k]);
                pe_if.kernel[0][r][k] = 8'(kr_g[r * KS + k]);
            end
        end
        pe_if.valid_in = v_g;
    endtask

    task automatic set_fill(input int iv, input int kv, input logic v);
        for (int i = 0; i < N; i++) begin
            im_g[i] = iv;
            kr_g[i] = kv;
        end
        v_g = v;
        drive();
    endtask

    task automatic check(input string tag);
        total++;
        assert (int'(pe_if.img_out) === eo_px)
        else begin
            bad++;
            $error("FAIL %s img_out observed=%0d expected=%0d", tag, pe_if.img_out, eo_px);
        end
        total++;
        assert (pe_if.valid_out === eo_v)
        else begin
            bad++;
            $error("FAIL %s valid_out observed=%0b expected=%0b", tag, pe_if.valid_out, eo_v);
        end
    endtask

    // One clock edge: advance the reference, then sample #1 after the edge.
    task automatic step(input string tag);
        int   cur_px;
        logic cur_v;
        cur_px = ref_px();
        cur_v  = v_g;
        @(posedge clk);
        if (!rst_n) begin
            eo_px = 0; eo_v = 1'b0;
            e1_px = 0; e1_v = 1'b0;
        end else begin
            eo_px = e1_px; eo_v = e1_v;
            e1_px = cur_px; e1_v = cur_v;
        end
        #1;
        check(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        eo_px = 0; eo_v = 1'b0;
        e1_px = 0; e1_v = 1'b0;
        check(tag);
    endtask

    initial begin
        int mx;
        total = 0;
        bad   = 0;
        e1_px = 0; e1_v = 1'b0;
        eo_px = 0; eo_v = 1'b0;

        // reset held with nonzero valid inputs
        rst_n = 1'b0;
        set_fill(200, 77, 1'b1);
        #2;
        check("reset_initial");
        step("reset_held_a");
        step("reset_held_b");

        set_fill(0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_release_a");
        step("post_release_b");
        step("post_release_c");

        set_fill(0, 0, 1'b1);
        step("zeros_s1");
        set_fill(0, 0, 1'b0);
        step("zeros_out");

        set_fill(1, 1, 1'b1);
        step("ones_s1");
        set_fill(0, 0, 1'b0);
        step("ones_out");
        step("ones_drain");

        set_fill(100, 1, 1'b1);
        step("hundreds_s1");
        set_fill(0, 0, 1'b0);
        step("hundreds_out");

        set_fill(255, 255, 1'b1);
        step("sat_s1");
        set_fill(0, 0, 1'b0);
        step("sat_out");

        // sum of 7 just below 2^SHIFT truncates to 0
        set_fill(0, 0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            im_g[i] = 1; kr_g[i] = 1;
        end
        drive();
        step("trunc_s1");
        set_fill(0, 0, 1'b0);
        step("trunc_out");

        // invalid window still computes
        set_fill(100, 1, 1'b0);
        step("noval_s1");
        set_fill(0, 0, 1'b0);
        step("noval_out");

        // back-to-back windows
        set_fill(1, 1, 1'b1);
        step("b2b_a");
        set_fill(100, 1, 1'b1);
        step("b2b_b");
        set_fill(0, 0, 1'b0);
        step("b2b_c");
        step("b2b_d");

        // back-to-back with reset between: both discarded
        set_fill(1, 1, 1'b1);
        step("rst_b2b_a");
        set_fill(100, 1, 1'b1);
        step("rst_b2b_b");
        async_reset("rst_b2b_async");
        step("rst_b2b_held");
        set_fill(0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_b2b_rel_a");
        step("rst_b2b_rel_b");

        // random windows streamed back-to-back
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0:       mx = 15;
                1:       mx = 60;
                default: mx = 255;
            endcase
            for (int i = 0; i < N; i++) begin
                im_g[i] = int'($urandom_range(0, mx));
                kr_g[i] = int'($urandom_range(0, mx));
            end
            v_g = 1'($urandom_range(0, 1));
            drive();
            step("random");
        end
        set_fill(0, 0, 1'b0);
        step("random_drain_a");
        step("random_drain_b");

        // permuted window gives the same result
        for (int i = 0; i < N; i++) begin
            im_g[i] = i + 1;
            kr_g[i] = 2 * i + 3;
        end
        v_g = 1'b1;
        drive();
        step("perm_a");
        for (int i = 0; i < N; i++) begin
            im_g[i] = N - i;
            kr_g[i] = 2 * (N - 1 - i) + 3;
        end
        drive();
        step("perm_b");
        set_fill(0, 0, 1'b0);
        step("perm_a_out");
        step("perm_b_out");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
